// File: rtl/fetch_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fetch_align
//  Description : Instruction fetch and alignment stage. Fetches 32-bit words
//                from instruction memory (at most one request in flight). It
//                buffers up to three 16-bit parcels and presents one aligned
//                instruction with its PC per downstream handshake.
//                Redirects flush the parcel buffer and restart fetch. A
//                response that was already in flight is dropped.
//  Config      : FETCH_RVC_EN defined   -> compressed (16-bit) instructions
//                                          and halfword-aligned targets.
//                FETCH_RVC_EN undefined -> 32-bit instructions only. Targets
//                                          are word aligned.
//  Ports       : i_clk, i_reset (async, active low)
//                i_redirect, i_redirect_pc          - fetch restart
//                o_imem_req, o_imem_addr, i_imem_ready,
//                i_imem_rvalid, i_imem_rdata        - instruction memory
//                o_valid, i_ready, o_instr, o_pc,
//                o_is_compressed                    - decode side
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_is_compressed
);

`ifdef FETCH_RVC_EN
    localparam logic RVC_EN = 1'b1;
`else
    localparam logic RVC_EN = 1'b0;
`endif

    localparam logic [31:0] RESET_FETCH  = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] RESET_BUF_PC = RVC_EN ? {RESET_PC[31:1], 1'b0} : RESET_FETCH;
    localparam logic        RESET_SKIP   = RVC_EN & RESET_PC[1];

    // Parcel buffer: entry 0 is the oldest halfword.
    logic [2:0][15:0] buf_q, buf_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      buf_pc_q, buf_pc_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic             skip_low_q, skip_low_d;
    // Holds off the first request until the cycle after reset release.
    logic             run_q, run_d;

    logic             is32;
    logic             valid;
    logic             fire;
    logic             req;
    logic             accept;
    logic             resp;
    logic [2:0][15:0] shifted;
    logic [1:0]       fill;
    logic [15:0]      first_hw;
    logic             unused_redirect_bits;

    // Bit 0 of the target is never used. Bit 1 is unused without compressed
    // support.
    assign unused_redirect_bits = &{1'b0, i_redirect_pc[1:0]};

    // Decode uses registered state only.
    assign is32   = !RVC_EN || (buf_q[0][1:0] == 2'b11);
    assign valid  = is32 ? (cnt_q >= 2'd2) : (cnt_q >= 2'd1);
    assign fire   = valid & i_ready;
    assign req    = run_q & ~outstanding_q & (cnt_q <= 2'd1) & ~i_redirect;
    assign accept = req & i_imem_ready;
    // A response without an outstanding request (stray after reset) is ignored.
    assign resp   = i_imem_rvalid & outstanding_q;

    assign o_imem_req      = req;
    assign o_imem_addr     = fetch_addr_q;
    assign o_valid         = valid;
    assign o_pc            = buf_pc_q;
    assign o_is_compressed = valid & ~is32;
    assign o_instr         = !valid ? 32'h0 : (is32 ? {buf_q[1], buf_q[0]} : {16'h0, buf_q[0]});

    always_comb begin
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        buf_pc_d      = buf_pc_q;
        fetch_addr_d  = fetch_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        skip_low_d    = skip_low_q;
        run_d         = 1'b1;
        shifted       = buf_q;
        fill          = cnt_q;
        first_hw      = skip_low_q ? i_imem_rdata[31:16] : i_imem_rdata[15:0];

        // Consume first, so a same-cycle response sees the freed slots.
        if (fire) begin
            if (is32) begin
                shifted  = {16'h0, 16'h0, buf_q[2]};
                fill     = cnt_q - 2'd2;
                buf_pc_d = buf_pc_q + 32'd4;
            end else begin
                shifted  = {16'h0, buf_q[2], buf_q[1]};
                fill     = cnt_q - 2'd1;
                buf_pc_d = buf_pc_q + 32'd2;
            end
        end
        buf_d = shifted;

        if (accept) begin
            outstanding_d = 1'b1;
            fetch_addr_d  = fetch_addr_q + 32'd4;
        end

        if (resp) begin
            outstanding_d = 1'b0;
            if (discard_q) begin
                discard_d = 1'b0;
            end else begin
                // Requests are only issued with count <= 1, so the appended
                // parcels always fit in the three slots.
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == fill)
                        buf_d[i] = first_hw;
                    if (!skip_low_q && (2'(i) == fill + 2'd1))
                        buf_d[i] = i_imem_rdata[31:16];
                end
                cnt_d      = skip_low_q ? fill + 2'd1 : fill + 2'd2;
                skip_low_d = 1'b0;
            end
        end else begin
            cnt_d = fill;
        end

        // The redirect overrides everything above. Any request still in
        // flight after this cycle must have its data dropped.
        if (i_redirect) begin
            cnt_d        = 2'd0;
            buf_pc_d     = RVC_EN ? {i_redirect_pc[31:1], 1'b0} : {i_redirect_pc[31:2], 2'b00};
            fetch_addr_d = {i_redirect_pc[31:2], 2'b00};
            skip_low_d   = RVC_EN & i_redirect_pc[1];
            discard_d    = outstanding_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            buf_q         <= '0;
            cnt_q         <= 2'd0;
            buf_pc_q      <= RESET_BUF_PC;
            fetch_addr_q  <= RESET_FETCH;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            skip_low_q    <= RESET_SKIP;
            run_q         <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            buf_pc_q      <= buf_pc_d;
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            skip_low_q    <= skip_low_d;
            run_q         <= run_d;
        end
    end

endmodule
`default_nettype wire
